// File: rtl/fp8_to_linear_decoder_pkg.sv
// ---------------------------------------------------------------------------
// fp8_pkg
//   Shared definitions for the FP8 <-> linear conversion blocks (encoder and
//   decoder). Holds the default field widths, the packed FP8 word layout and
//   the decoder state encoding.
// ---------------------------------------------------------------------------
package fp8_pkg;

  localparam int unsigned FP8_EXP_W  = 3;
  localparam int unsigned FP8_MANT_W = 4;
  localparam int unsigned FP8_DATA_W = 12;

  // Largest decoded magnitude: full significand shifted by the largest exponent.
  localparam int unsigned FP8_MAX_MAG = ((1 << FP8_MANT_W) - 1) << ((1 << FP8_EXP_W) - 1);

  typedef struct packed {
    logic                  sign;
    logic [FP8_EXP_W-1:0]  exp;
    logic [FP8_MANT_W-1:0] sig;
  } fp8_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fp8_to_linear_decoder_sign_apply.sv
// ---------------------------------------------------------------------------
// fp8_sign_apply
//   Combinational conditional two's-complement negate. Shared by the decoder
//   output path and the encoder sign path.
//   Ports:
//     i_neg  - negate when high
//     i_mag  - W-bit unsigned magnitude
//     o_val  - i_mag or -i_mag (W-bit two's complement); -0 yields 0
// ---------------------------------------------------------------------------
module fp8_sign_apply #(
  parameter int unsigned W = 12
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_mag,
  output logic [W-1:0] o_val
);

  always_comb begin
    o_val = i_mag;
    if (i_neg) begin
      o_val = '0 - i_mag;
    end
  end

endmodule

// File: rtl/fp8_to_linear_decoder.sv
// ---------------------------------------------------------------------------
// fp8_to_linear_decoder
//   Expands an FP8 word {S, E, F} into the linear two's-complement value
//   D = (-1)^S * F * 2^E. No implicit leading bit: F is taken literally.
//   Valid/ready handshake on both sides; one word in flight at a time.
//
//   Build option (macro FP8_DECODER_BARREL_EN):
//     undefined - iterative shifter, IDLE -> SHIFT -> DONE, latency E+2
//     defined   - single-cycle barrel shift, IDLE -> DONE, latency 1
//
//   Parameters: EXP_W, MANT_W, DATA_W. DATA_W-1 >= MANT_W + 2^EXP_W - 1 is
//   required so the largest magnitude and its negation both fit.
//
//   Ports:
//     clk       - rising-edge clock
//     rst_n     - asynchronous active-low reset
//     in_valid  - input word present
//     in_ready  - decoder can accept a word (IDLE only)
//     in_sign   - S
//     in_exp    - E
//     in_sig    - F
//     out_valid - out_data is valid
//     out_ready - consumer takes out_data
//     out_data  - decoded linear value D
// ---------------------------------------------------------------------------
module fp8_to_linear_decoder
  import fp8_pkg::*;
#(
  parameter int unsigned EXP_W  = FP8_EXP_W,
  parameter int unsigned MANT_W = FP8_MANT_W,
  parameter int unsigned DATA_W = FP8_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_sig,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  state_t              r_state;
  state_t              w_next_state;
  logic                w_in_ready;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic [DATA_W-1:0]   w_sig_ext;
  logic [DATA_W-1:0]   w_mag;
  logic                w_neg;
  logic [DATA_W-1:0]   w_signed;

  assign w_sig_ext = {{(DATA_W-MANT_W){1'b0}}, in_sig};

`ifdef FP8_DECODER_BARREL_EN
  // Sign and shift are applied straight from the input word on the accept edge.
  assign w_mag = w_sig_ext << in_exp;
  assign w_neg = in_sign;
`else
  logic [DATA_W-1:0] r_mag;
  logic [EXP_W-1:0]  r_cnt;
  logic              r_sgn;

  assign w_mag = r_mag;
  assign w_neg = r_sgn;
`endif

  fp8_sign_apply #(
    .W (DATA_W)
  ) u_sign_apply (
    .i_neg (w_neg),
    .i_mag (w_mag),
    .o_val (w_signed)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
`ifdef FP8_DECODER_BARREL_EN
          w_next_state = DONE;
`else
          w_next_state = SHIFT;
`endif
        end
      end
`ifndef FP8_DECODER_BARREL_EN
      SHIFT: begin
        if (r_cnt == '0) begin
          w_next_state = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
`ifndef FP8_DECODER_BARREL_EN
      r_mag       <= '0;
      r_cnt       <= '0;
      r_sgn       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
`ifdef FP8_DECODER_BARREL_EN
            r_out_data  <= w_signed;
            r_out_valid <= 1'b1;
`else
            r_mag <= w_sig_ext;
            r_cnt <= in_exp;
            r_sgn <= in_sign;
`endif
          end
        end
`ifndef FP8_DECODER_BARREL_EN
        SHIFT: begin
          if (r_cnt != '0) begin
            r_mag <= r_mag << 1;
            r_cnt <= r_cnt - EXP_W'(1);
          end else begin
            r_out_data  <= w_signed;
            r_out_valid <= 1'b1;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_fp8_to_linear_decoder.sv
module tb_fp8_to_linear_decoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [2:0]  in_exp;
  logic [3:0]  in_sig;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;

  int n_checks;
  int n_err;

  fp8_to_linear_decoder #(
    .EXP_W  (3),
    .MANT_W (4),
    .DATA_W (12)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_sig    (in_sig),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        s;
    bit [2:0]  e;
    bit [3:0]  f;
    bit [11:0] d;
    int        lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input bit [2:0] e);
`ifdef FP8_DECODER_BARREL_EN
    return 1;
`else
    return int'(e) + 2;
`endif
  endfunction

  // Present a word, wait for acceptance and for out_valid. Returns at
  // posedge+1 with out_valid high (ok=1) or after a bounded wait (ok=0).
  // lat counts edges from the handshake cycle to the first out_valid cycle.
  task automatic xfer(input bit s, input bit [2:0] e, input bit [3:0] f,
                      output logic [11:0] d, output int lat, output bit ok);
    int w;
    in_sign  = s;
    in_exp   = e;
    in_sig   = f;
    in_valid = 1'b1;
    w = 0;
    lat = 0;
    d = 'x;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      ok = 1'b0;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    lat = 1;
    in_valid = 1'b0;
    // Scramble inputs after acceptance; the word in flight must not change.
    in_sign = ~s;
    in_exp  = ~e;
    in_sig  = ~f;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = out_valid;
    d  = out_data;
  endtask

  // Reference encoder: smallest exponent whose rounded significand fits,
  // saturating to E=7,F=15 beyond the representable range.
  task automatic enc(input int dv, output bit s, output bit [2:0] e,
                     output bit [3:0] f, output bit sat);
    int  m;
    int  q;
    bit  found;
    s = (dv < 0);
    m = s ? -dv : dv;
    e = 3'd7;
    f = 4'd15;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      q = (m + ((k == 0) ? 0 : (1 << (k - 1)))) >> k;
      if (!found && q <= 15) begin
        found = 1'b1;
        e = 3'(k);
        f = 4'(q);
      end
    end
    sat = !found;
  endtask

  logic [11:0] d;
  int          lat;
  bit          ok;

  initial begin
    n_checks  = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_sig    = '0;
    out_ready = 1'b1;

    vecs[0]  = '{1'b0, 3'd0, 4'b1010, 12'h00A, 2};
    vecs[1]  = '{1'b1, 3'd7, 4'b1111, 12'h880, 9};
    vecs[2]  = '{1'b1, 3'd3, 4'b0000, 12'h000, 5};
    vecs[3]  = '{1'b0, 3'd2, 4'b1001, 12'h024, 4};
    vecs[4]  = '{1'b0, 3'd7, 4'b1111, 12'h780, 9};
    vecs[5]  = '{1'b1, 3'd0, 4'b0001, 12'hFFF, 2};
    vecs[6]  = '{1'b0, 3'd4, 4'b0011, 12'h030, 6};
    vecs[7]  = '{1'b1, 3'd5, 4'b0101, 12'hF60, 7};
    vecs[8]  = '{1'b0, 3'd1, 4'b1000, 12'h010, 3};
    vecs[9]  = '{1'b1, 3'd6, 4'b0111, 12'hE40, 8};
    vecs[10] = '{1'b0, 3'd3, 4'b0000, 12'h000, 5};
    vecs[11] = '{1'b1, 3'd2, 4'b1111, 12'hFC4, 4};

    // Reset state
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, out_ready held high
    for (int i = 0; i < 12; i++) begin
      xfer(vecs[i].s, vecs[i].e, vecs[i].f, d, lat, ok);
      chk($sformatf("vec%0d_timeout", i), 32'(ok), 32'd1);
      chk($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].d));
`ifdef FP8_DECODER_BARREL_EN
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
`else
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
`endif
      @(posedge clk); #1;
      chk($sformatf("vec%0d_drain_valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d_drain_ready", i), 32'(in_ready), 32'd1);
    end

    // Backpressure: hold result 5 cycles, second word must be refused
    out_ready = 1'b0;
    xfer(1'b0, 3'd2, 4'b1001, d, lat, ok);
    chk("bp_timeout", 32'(ok), 32'd1);
    chk("bp_lat", 32'(lat), 32'(exp_latency(3'd2)));
    in_sign  = 1'b1;
    in_exp   = 3'd0;
    in_sig   = 4'b0001;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_data", c), 32'(out_data), 32'h024);
      chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_second_word", 32'(out_valid), 32'd0);

    // Reset during SHIFT (E=6)
    in_sign  = 1'b0;
    in_exp   = 3'd6;
    in_sig   = 4'b0101;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_shift_valid", 32'(out_valid), 32'd0);
    chk("rst_shift_ready", 32'(in_ready), 32'd1);
    chk("rst_shift_data", 32'(out_data), 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset during DONE
    out_ready = 1'b0;
    xfer(1'b0, 3'd5, 4'b0011, d, lat, ok);
    chk("rst_done_pre_data", 32'(d), 32'h060);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done_valid", 32'(out_valid), 32'd0);
    chk("rst_done_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Next word after reset decodes correctly
    xfer(1'b1, 3'd4, 4'b1001, d, lat, ok);
    chk("post_rst_timeout", 32'(ok), 32'd1);
    chk("post_rst_data", 32'(d), 32'hF70);
    chk("post_rst_lat", 32'(lat), 32'(exp_latency(3'd4)));
    @(posedge clk); #1;

    // Round trip over every 12-bit linear value
    for (int v = -2048; v < 2048; v++) begin
      bit       s;
      bit [2:0] e;
      bit [3:0] f;
      bit       sat;
      int       got;
      int       err;
      enc(v, s, e, f, sat);
      xfer(s, e, f, d, lat, ok);
      n_checks++;
      got = int'($signed(d));
      err = (v > got) ? (v - got) : (got - v);
      if (!ok) begin
        n_err++;
        $display("FAIL rt_timeout v=%0d", v);
      end else if (sat) begin
        if (got != (s ? -1920 : 1920)) begin
          n_err++;
          $display("FAIL rt_sat v=%0d: got %0d expected %0d", v, got, s ? -1920 : 1920);
        end
      end else if (2 * err > (1 << e)) begin
        n_err++;
        $display("FAIL rt_err v=%0d e=%0d f=%0d: got %0d error %0d exceeds half of %0d",
                 v, e, f, got, err, 1 << e);
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fp8_to_linear_decoder.md
Name: fp8_to_linear_decoder

Overview:
- Inverse of the team's linear-to-floating-point encoder: expands an 8-bit sign/exponent/significand word {S, E[2:0], F[3:0]} back to a 12-bit two's-complement linear value D = (-1)^S * F * 2^E.
- Sits after the encoder/rounding stage so test harnesses can round-trip a value and measure the quantisation error.
- Multi-cycle iterative shifter with valid/ready handshakes on input and output.

Parameters:
- EXP_W, 3, exponent width. The bound DATA_W-1 >= MANT_W + 2^EXP_W - 1 must hold.
- MANT_W, 4, significand width.
- DATA_W, 12, linear output width (two's complement).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  decoder can accept a word.
- in_sign  input  1  S.
- in_exp  input  EXP_W  E.
- in_sig  input  MANT_W  F.
- out_valid  output  1  D is valid.
- out_ready  input  1  consumer takes D.
- out_data  output  DATA_W  decoded linear value D.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE
  - in_ready=1, out_valid=0, out_data=0
  - internal magnitude and count=0
  - sign latch=0
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, the word is accepted and latched: mag={zeros,in_sig}, cnt=in_exp, sgn=in_sign.
  - Go to SHIFT.
- SHIFT:
  - in_ready=0.
  - If cnt!=0: mag<=mag<<1, cnt<=cnt-1. Stay in SHIFT.
  - If cnt==0: out_data<= sgn ? -mag : mag (DATA_W-bit two's complement). out_valid<=1. Go to DONE.
- DONE:
  - out_valid=1, with out_data held stable.
  - When out_ready=1, that cycle completes the transfer: out_valid<=0, next state IDLE.
  - in_ready stays 0 in DONE, so no overlap occurs.
- Latency: E+2 cycles from the accept edge to the first out_valid cycle, which is 2 cycles minimum and 9 maximum. Throughput is one word per E+3 cycles with out_ready held high.
- Width rules:
  - The magnitude never exceeds 15*2^7=1920, so no overflow occurs at DATA_W=12.
  - Negation is always representable; the most negative output is -1920.
- Boundary conditions:
  - F=0 with S=1 (negative zero) outputs 0, never 0x800.
  - E=0 means no shift cycles.
  - Denormal-looking inputs (F<8) are decoded literally as F*2^E. No implicit leading bit.
- in_valid while busy is ignored. The source must hold the word until in_ready is seen high.
- out_ready while out_valid=0 is ignored.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation: out_valid drops immediately and the word is lost.
- Inputs are sampled only on the accept edge. Later changes on in_* do not affect the word in flight.

Optional Feature:
- Macro: FP8_DECODER_BARREL_EN.
- Defined: the SHIFT state is removed. The accept edge computes out_data=(sgn?-1:1)*(F<<E) directly and sets out_valid. Latency is 1 cycle for every E, and the FSM has only IDLE and DONE.
- Undefined: the iterative shifter described above is used.
- Handshake, reset and boundary behaviour are identical in both builds.

Decomposition:
- Shared package fp8_pkg holds:
  - EXP_W, MANT_W and DATA_W constants.
  - A packed struct fp8_t {sign, exp, sig}.
  - The state enum {IDLE, SHIFT, DONE}.
  - The encoder uses the same package.
- One natural sub-module, fp8_sign_apply: a combinational conditional two's-complement negate, reused by the encoder's sign path.

Test Plan:
- S=0,E=0,F=0b1010, out_ready=1 -> out_data=10 (0x00A), out_valid exactly 2 cycles after accept.
- S=1,E=7,F=0b1111 -> out_data=-1920 (0x880), 9-cycle latency. With FP8_DECODER_BARREL_EN defined, latency is 1.
- S=1,E=3,F=0 -> out_data=0x000 (no negative zero).
- Backpressure:
  - Decode S=0,E=2,F=0b1001 (result 36 = 0x024) with out_ready=0 for 5 cycles.
  - out_valid and out_data=0x024 must hold, and in_ready must stay 0.
  - A second in_valid during this time must not be accepted.
- Reset mid-operation: assert rst_n=0 during SHIFT of E=6 -> out_valid=0, in_ready=1 asynchronously. The next word decodes correctly.
- Round trip: sweep every 12-bit input through the existing encoder, then this decoder. |D_in - D_out| must stay within half an LSB of 2^E, and saturated inputs must decode to ±1920.
